// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifetch_pkg;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Instruction returned after reset, flush or a faulting fetch
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Legal range of wait states per fetch
    localparam int WAIT_CYCLES_MIN = 0;
    localparam int WAIT_CYCLES_MAX = 15;

    // Ceiling log2, used to size word indices
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 32 instruction storage: synchronous write, registered read on enable.
// Read and write share one edge, so a read of the word being written returns
// the old contents.
module instr_mem_array
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Loader write and fetch read; non-blocking ordering gives read-before-write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-memory responder between the PC and the IF/ID register.
// Handshake: a fetch is taken on any cycle where start_i & req_i & !flush_i
// and the responder is idle or presenting a response; while stall_o is high
// the PC holds req_i/addr_i; valid_o pulses for one cycle with the result.
module instr_fetch_resp
    import ifetch_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    req_i,
    input  logic [31:0]             addr_i,
    input  logic                    flush_i,
    input  logic                    ld_we_i,
    input  logic [clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [31:0]             ld_data_i,
    output logic [31:0]             inst_o,
    output logic [31:0]             pc_o,
    output logic                    valid_o,
    output logic                    err_o,
    output logic                    stall_o
);

    localparam int AW = clog2(DEPTH);
    // Out-of-range settings are clamped so the 4-bit counter stays meaningful
    localparam int WC = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX :
                        (WAIT_CYCLES < WAIT_CYCLES_MIN) ? WAIT_CYCLES_MIN : WAIT_CYCLES;
    localparam logic [3:0] WC_L = 4'(WC);

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   addr_q;
    logic          inst_sel;
    logic [31:0]   rd_data;

    logic          accept;
    logic          in_wait;
    logic          resp_load;
    logic [31:0]   resp_addr;
    logic          resp_err;
    logic [AW-1:0] rd_idx;

    // Acceptance, response-load decision, error check and Mealy stall
    always_comb begin
        in_wait   = (state == WAIT);
        accept    = start_i & req_i & ~flush_i & ((state == IDLE) | (state == RESP));
        resp_addr = in_wait ? addr_q : addr_i;
        if (in_wait) begin
            resp_load = ~flush_i & (cnt == 4'd1);
        end else begin
            resp_load = accept & (WC == 0);
        end
        resp_err  = (resp_addr[1:0] != 2'b00) | ((resp_addr >> (AW + 2)) != 32'd0);
        rd_idx    = resp_addr[AW+1:2];
        stall_o   = (accept & (WC != 0)) | (in_wait & ~flush_i);
    end

    instr_mem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk_i),
        .we   (ld_we_i),
        .waddr(ld_addr_i),
        .wdata(ld_data_i),
        .re   (resp_load),
        .raddr(rd_idx),
        .rdata(rd_data)
    );

    // Fetch sequencing FSM with wait counter and registered response fields
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= 32'd0;
            pc_o     <= 32'd0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            inst_sel <= 1'b0;
        end else begin
            valid_o <= resp_load;
            if (resp_load) begin
                pc_o     <= resp_addr;
                err_o    <= resp_err;
                inst_sel <= ~resp_err;
            end else if (flush_i) begin
                inst_sel <= 1'b0;
            end

            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q <= addr_i;
                        if (WC == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WC_L;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Faulted or flushed results present the NOP word; otherwise the read data
    assign inst_o = inst_sel ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Bench for instr_fetch_resp: three instances (0, 1 and 3 wait states) share
// one stimulus stream and are each checked against a cycle-numbered model.
module tb_instr_fetch_resp;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start, req, flush, ld_we;
    logic [31:0]   addr, ld_data;
    logic [AW-1:0] ld_addr;

    logic [31:0] inst [3];
    logic [31:0] pc   [3];
    logic [2:0]  valid, err, stall;

    instr_fetch_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .NOP_WORD(NOP)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .req_i(req), .addr_i(addr),
        .flush_i(flush), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .inst_o(inst[0]), .pc_o(pc[0]), .valid_o(valid[0]), .err_o(err[0]), .stall_o(stall[0]));

    instr_fetch_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .NOP_WORD(NOP)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .req_i(req), .addr_i(addr),
        .flush_i(flush), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .inst_o(inst[1]), .pc_o(pc[1]), .valid_o(valid[1]), .err_o(err[1]), .stall_o(stall[1]));

    instr_fetch_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .NOP_WORD(NOP)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .req_i(req), .addr_i(addr),
        .flush_i(flush), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .inst_o(inst[2]), .pc_o(pc[2]), .valid_o(valid[2]), .err_o(err[2]), .stall_o(stall[2]));

    // reference model: memory image, outstanding fetch with its due cycle,
    // and the expected registered outputs of the current cycle
    logic [31:0] mmem [DEPTH];
    bit          m_pend [3];
    int          m_due  [3];
    logic [31:0] m_addr [3];
    bit          e_valid [3];
    bit          e_err   [3];
    logic [31:0] e_inst  [3];
    logic [31:0] e_pc    [3];
    int          cyc;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int wc_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * DEPTH);
    endfunction

    // scoreboard compare
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i]  = 1'b0;
            m_due[i]   = 0;
            m_addr[i]  = 32'd0;
            e_valid[i] = 1'b0;
            e_err[i]   = 1'b0;
            e_inst[i]  = NOP;
            e_pc[i]    = 32'd0;
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s_valid%0d", tag, i), 32'(valid[i]), 32'd0);
            check_val($sformatf("%s_inst%0d", tag, i), inst[i], NOP);
            check_val($sformatf("%s_pc%0d", tag, i), pc[i], 32'd0);
            check_val($sformatf("%s_err%0d", tag, i), 32'(err[i]), 32'd0);
            check_val($sformatf("%s_stall%0d", tag, i), 32'(stall[i]), 32'd0);
        end
    endtask

    // driver
    task automatic drive(input bit s, input bit r, input logic [31:0] a, input bit f);
        start = s;
        req   = r;
        addr  = a;
        flush = f;
    endtask

    // one clock: compare at the falling edge, advance the model, cross the rising edge
    task automatic step();
        bit acc [3];
        bit exp_stall;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            acc[i]    = start && req && !flush && !m_pend[i];
            exp_stall = (acc[i] && wc_of(i) > 0) || (m_pend[i] && !flush);
            check_val($sformatf("valid%0d", i), 32'(valid[i]), 32'(e_valid[i]));
            check_val($sformatf("inst%0d", i), inst[i], e_inst[i]);
            check_val($sformatf("pc%0d", i), pc[i], e_pc[i]);
            check_val($sformatf("stall%0d", i), 32'(stall[i]), 32'(exp_stall));
            if (e_valid[i]) begin
                check_val($sformatf("err%0d", i), 32'(err[i]), 32'(e_err[i]));
            end
        end
        for (int i = 0; i < 3; i++) begin
            e_valid[i] = 1'b0;
            if (flush) begin
                m_pend[i] = 1'b0;
                e_inst[i] = NOP;
            end else begin
                if (acc[i]) begin
                    m_pend[i] = 1'b1;
                    m_addr[i] = addr;
                    m_due[i]  = cyc + 1 + wc_of(i);
                end
                if (m_pend[i] && m_due[i] == cyc + 1) begin
                    e_valid[i] = 1'b1;
                    e_pc[i]    = m_addr[i];
                    e_err[i]   = addr_bad(m_addr[i]);
                    e_inst[i]  = e_err[i] ? NOP : mmem[(m_addr[i] / 4) % DEPTH];
                    m_pend[i]  = 1'b0;
                end
            end
        end
        if (ld_we) begin
            mmem[ld_addr] = ld_data;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) begin
            step();
        end
    endtask

    task automatic scenario_basic(input string tag);
        drive(1'b1, 1'b1, 32'h4, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        check_val({tag, "_valid_w1"}, 32'(valid[1]), 32'd1);
        check_val({tag, "_inst_w1"}, inst[1], 32'h22);
        check_val({tag, "_pc_w1"}, pc[1], 32'h4);
        step_n(4);
    endtask

    initial begin
        int r;
        logic [31:0] a;
        cyc = 0;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = 32'h0;

        #3 check_reset("por");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // load the whole image; words 0..3 get the known pattern
        for (int i = 0; i < DEPTH; i++) begin
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
            step();
        end
        ld_we = 1'b0;

        scenario_basic("s1");

        // back-to-back fetches with req held
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'(4 * k), 1'b0);
            step();
            check_val($sformatf("b2b%0d_valid_w0", k), 32'(valid[0]), 32'd1);
            check_val($sformatf("b2b%0d_inst_w0", k), inst[0], 32'((k + 1) * 32'h11));
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step_n(6);

        // misaligned and out-of-range fetches
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 32'h6 : 32'(4 * DEPTH);
            drive(1'b1, 1'b1, a, 1'b0);
            step();
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            check_val($sformatf("err%0d_valid_w0", k), 32'(valid[0]), 32'd1);
            check_val($sformatf("err%0d_err_w0", k), 32'(err[0]), 32'd1);
            check_val($sformatf("err%0d_inst_w0", k), inst[0], NOP);
            step_n(5);
        end

        // flush two cycles after acceptance, then a new request
        drive(1'b1, 1'b1, 32'h8, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        drive(1'b1, 1'b1, 32'hC, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step_n(3);
        check_val("flush_valid_w3", 32'(valid[2]), 32'd1);
        check_val("flush_inst_w3", inst[2], 32'h44);
        step_n(3);

        // loader write colliding with the read edge
        drive(1'b1, 1'b1, 32'h4, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        ld_we   = 1'b1;
        ld_addr = AW'(1);
        ld_data = 32'hAA;
        step();
        ld_we = 1'b0;
        check_val("coll_inst_w1", inst[1], 32'h22);
        step_n(4);
        drive(1'b1, 1'b1, 32'h4, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step_n(4);
        check_val("refetch_inst_w3", inst[2], 32'hAA);

        // reset while the slow instance is waiting
        drive(1'b1, 1'b1, 32'h8, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        #2 rst = 1'b1;
        #1 check_reset("mid");
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        step_n(5);
        ld_we   = 1'b1;
        ld_addr = AW'(1);
        ld_data = 32'h22;
        step();
        ld_we = 1'b0;
        scenario_basic("s1b");

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 7) a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (r == 8) a = 32'(4 * DEPTH + 4 * $urandom_range(0, 255));
            else             a = $urandom;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, a,
                  $urandom_range(0, 9) == 0);
            ld_we   = ($urandom_range(0, 6) == 0);
            ld_addr = AW'($urandom_range(0, DEPTH - 1));
            ld_data = $urandom;
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        ld_we = 1'b0;
        step_n(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_resp.md
Name: instr_fetch_resp

Overview:
Instruction-memory responder: the fetch-side counterpart of the PC register. Accepts fetch requests carrying the PC address and returns the addressed 32-bit instruction after a configurable number of wait states. Asserts a stall back to the PC/hazard logic while a fetch is outstanding, and supports pipeline flush and a boot-time loader write port. Sits between the PC and the IF/ID pipeline register.

Parameters:
DEPTH, 256, instruction words stored; power of two, 4..65536
WAIT_CYCLES, 1, wait states per fetch, 0..15
NOP_WORD, 32'h0000_0000, instruction returned on reset, flush or error

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  CPU run enable; requests are accepted only while high
req_i  input  1  fetch request valid; held by the PC while stalled
addr_i  input  32  byte address of the fetch (PC value)
flush_i  input  1  discard the in-flight fetch (branch/jump taken)
ld_we_i  input  1  loader write enable
ld_addr_i  input  log2(DEPTH)  loader word index
ld_data_i  input  32  loader write data
inst_o  output  32  fetched instruction (registered)
pc_o  output  32  address of the instruction on inst_o (registered)
valid_o  output  1  inst_o/pc_o valid, one-cycle pulse per fetch (registered)
err_o  output  1  fetch error, qualified by valid_o (registered)
stall_o  output  1  hold the PC; combinational (Mealy)

Behaviour:
- Reset (async, rst_i=1): state IDLE, cnt=0, inst_o=NOP_WORD, pc_o=0, valid_o=0, err_o=0, stall_o=0. Memory contents are not reset. Reset mid-fetch aborts it with no response.
- FSM states: IDLE, WAIT, RESP. Acceptance = start_i & req_i & !flush_i & state in {IDLE, RESP}.
- On acceptance: latch addr_i. If WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with cnt=WAIT_CYCLES.
- In WAIT: cnt decrements each cycle. When cnt=1, go to RESP.
- Memory read occurs on the edge entering RESP. inst_o, pc_o and err_o are loaded on that edge, and valid_o=1 for exactly that RESP cycle.
- Latency: a request accepted in cycle T gets its response valid in cycle T+1+WAIT_CYCLES.
- In RESP with no acceptance: return to IDLE, and valid_o drops next cycle. inst_o and pc_o hold their last values.
- stall_o = (acceptance & WAIT_CYCLES>0) | (state==WAIT). It is never asserted when WAIT_CYCLES=0.
- Throughput: one fetch per WAIT_CYCLES+1 cycles, back-to-back via acceptance in RESP.
- Word index = addr_i[log2(DEPTH)+1:2].
- Error: set if addr_i[1:0]!=0 or addr_i[31:log2(DEPTH)+2]!=0. An errored response still pulses valid_o, with err_o=1 and inst_o=NOP_WORD.
- flush_i has priority over everything except reset:
  - In WAIT: go to IDLE, no response, stall_o=0 that cycle.
  - In RESP: go to IDLE with no new acceptance.
  - The next cycle always has valid_o=0 and inst_o=NOP_WORD.
- start_i low: no new acceptance; a fetch already in flight completes normally.
- Loader: ld_we_i writes mem[ld_addr_i] on the clock edge, independent of the FSM. A write to the word being read on the same edge is not visible; old data is returned (read-before-write).
- Simultaneous req_i and flush_i: the request is dropped. The PC re-presents its address next cycle.

Decomposition:
- Shared package (ifetch_pkg):
  - state enum {IDLE, WAIT, RESP}
  - NOP_WORD default
  - clog2 function
  - WAIT_CYCLES legal range constant
- One sub-module, instr_mem_array: DEPTH x 32 storage with a synchronous write port, a read port sampled on enable, and read-before-write on collision.
- FSM, counter, error check and output registers stay in instr_fetch_resp.

Test Plan:
- Reset then load: load mem[0..3]=0x11,0x22,0x33,0x44. With WAIT_CYCLES=1, req at T addr=0x4 -> stall_o=1 in T and T+1; valid_o=1 at T+2 with inst_o=0x22, pc_o=0x4, err_o=0.
- WAIT_CYCLES=0, start_i=1, req_i held, addr 0x0,0x4,0x8 on consecutive cycles -> valid_o high for three consecutive cycles with 0x11,0x22,0x33; stall_o never asserted.
- Misaligned addr=0x6 -> valid_o=1, err_o=1, inst_o=NOP_WORD. Out-of-range addr=4*DEPTH -> same result.
- WAIT_CYCLES=3, flush_i at T+2 after acceptance at T -> no valid_o pulse; stall_o low from T+2; next req at T+3 is accepted and returns data at T+7.
- Loader collision: ld_we_i writes 0xAA to word 1 on the edge that enters RESP for addr 0x4 -> inst_o=0x22. A refetch of addr 0x4 returns 0xAA.
- rst_i asserted mid-WAIT (asynchronously, between edges) -> all outputs at reset values immediately; no response after release. The first new request behaves per the first scenario.
